// File: rtl/sysa_seq_ctrl.sv
// sysa_seq_ctrl: command-driven sequencer feeding a 3x3 systolic array and streaming its results
module sysa_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic                  caravel_wb_clk_i,
    input  logic                  caravel_wb_rst_i,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [31:0]           cmd_data,
    output logic                  sa_en,
    output logic [9*DATA_W-1:0]   sa_w,
    output logic [3*DATA_W-1:0]   sa_in,
    input  logic [ACC_W-1:0]      sa_out1,
    input  logic [ACC_W-1:0]      sa_out2,
    input  logic [ACC_W-1:0]      sa_out3,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_W-1:0]      res_data,
    output logic [3:0]            res_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [1:0] {IDLE, RUN, EMIT} state_t;
    state_t                state_q, state_d;
    logic [2:0]            t_q, t_d;
    logic [3:0]            k_q, k_d, wptr_q, wptr_d;
    logic [1:0]            iptr_q, iptr_d;
    logic                  err_q, err_d, done_q, done_d;
    logic [DATA_W-1:0]     w_q [9], w_d [9];
    logic [3*DATA_W-1:0]   irow_q [3], irow_d [3];
    logic [ACC_W-1:0]      res_q [9], res_d [9];
    logic [ACC_W-1:0]      col [3];
    logic                  cmd_fire;
    assign col      = '{sa_out1, sa_out2, sa_out3};
    assign cmd_fire = cmd_valid && state_q == IDLE;
    // next-state: command decode in IDLE, skewed capture in RUN, handshake-driven drain in EMIT
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        k_d     = k_q;
        wptr_d  = wptr_q;
        iptr_d  = iptr_q;
        err_d   = err_q;
        done_d  = 1'b0;
        w_d     = w_q;
        irow_d  = irow_q;
        res_d   = res_q;
        if (cmd_fire && cmd_op == 2'd0) begin
            for (int i = 0; i < 9; i++) if (wptr_q == 4'(i)) w_d[i] = cmd_data[DATA_W-1:0];
            wptr_d = wptr_q == 4'd8 ? 4'd0 : wptr_q + 4'd1;
        end
        if (cmd_fire && cmd_op == 2'd1) begin
            for (int r = 0; r < 3; r++) if (iptr_q == 2'(r)) irow_d[r] = cmd_data[3*DATA_W-1:0];
            iptr_d = iptr_q == 2'd3 ? iptr_q : iptr_q + 2'd1;
            err_d  = err_q || iptr_q == 2'd3;
        end
        if (cmd_fire && cmd_op == 2'd2) begin
            state_d = iptr_q == 2'd3 ? RUN : IDLE;
            t_d     = 3'd0;
            err_d   = err_q || iptr_q != 2'd3;
        end
        if (cmd_fire && cmd_op == 2'd3) begin
            w_d    = '{default: '0};
            irow_d = '{default: '0};
            wptr_d = 4'd0;
            iptr_d = 2'd0;
            err_d  = 1'b0;
        end
        if (state_q == RUN) begin
            t_d     = t_q == 3'd6 ? 3'd0 : t_q + 3'd1;
            state_d = t_q == 3'd6 ? EMIT : RUN;
            for (int r = 0; r < 3; r++)
                for (int j = 0; j < 3; j++)
                    if (t_q == 3'(r + j + 1)) res_d[r*3+j] = col[j];
        end
        if (state_q == EMIT && res_ready) begin
            done_d  = k_q == 4'd8;
            k_d     = k_q == 4'd8 ? 4'd0 : k_q + 4'd1;
            iptr_d  = k_q == 4'd8 ? 2'd0 : iptr_q;
            state_d = k_q == 4'd8 ? IDLE : EMIT;
        end
    end
    // state and datapath registers, cleared asynchronously
    always_ff @(posedge caravel_wb_clk_i or posedge caravel_wb_rst_i) begin
        if (caravel_wb_rst_i) begin
            state_q <= IDLE;
            t_q     <= '0;
            k_q     <= '0;
            wptr_q  <= '0;
            iptr_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            w_q     <= '{default: '0};
            irow_q  <= '{default: '0};
            res_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            k_q     <= k_d;
            wptr_q  <= wptr_d;
            iptr_q  <= iptr_d;
            err_q   <= err_d;
            done_q  <= done_d;
            w_q     <= w_d;
            irow_q  <= irow_d;
            res_q   <= res_d;
        end
    end
    // outputs decoded from registered state; input rows enter diagonally, lane j lagging by j cycles
    always_comb begin
        cmd_ready = state_q == IDLE;
        sa_en     = state_q == RUN;
        busy      = state_q != IDLE;
        res_valid = state_q == EMIT;
        res_idx   = k_q;
        done      = done_q;
        err       = err_q;
        res_data  = '0;
        sa_w      = '0;
        sa_in     = '0;
        for (int i = 0; i < 9; i++) begin
            sa_w[i*DATA_W+:DATA_W] = w_q[i];
            if (k_q == 4'(i)) res_data = res_q[i];
        end
        for (int j = 0; j < 3; j++)
            for (int r = 0; r < 3; r++)
                if (state_q == RUN && t_q == 3'(r + j)) sa_in[j*DATA_W+:DATA_W] = irow_q[r][j*DATA_W+:DATA_W];
    end
endmodule

// File: tb/tb_sysa_seq_ctrl.sv
// tb_sysa_seq_ctrl: directed scenario tests for the systolic array sequencer
module tb_sysa_seq_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, sa_en, res_valid, res_ready = 1'b0, busy, done, err;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_data = 32'd0;
    logic [71:0] sa_w, exp_w;
    logic [23:0] sa_in;
    logic [15:0] sa_out1, sa_out2, sa_out3, res_data;
    logic [3:0]  res_idx;
    int          run_t = 0, checks = 0, fails = 0;
    logic [23:0] skew [7] = '{24'h000001, 24'h000204, 24'h030507, 24'h060800, 24'h090000, 24'h000000, 24'h000000};

    sysa_seq_ctrl dut (
        .caravel_wb_clk_i(clk), .caravel_wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .sa_en(sa_en), .sa_w(sa_w), .sa_in(sa_in),
        .sa_out1(sa_out1), .sa_out2(sa_out2), .sa_out3(sa_out3),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) run_t <= sa_en ? run_t + 1 : 0;
    assign sa_out1 = 16'(run_t);
    assign sa_out2 = 16'h0100 + 16'(run_t);
    assign sa_out3 = 16'h0200 + 16'(run_t);

    function automatic logic [15:0] exp_res(input int k);
        return 16'(256 * (k % 3) + k / 3 + k % 3 + 1);
    endfunction

    task automatic cmd(input logic [1:0] op, input logic [31:0] d);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({sa_en, busy, res_valid, done, err} !== 5'b0 || sa_w !== 72'd0 || sa_in !== 24'd0 || res_data !== 16'd0 || res_idx !== 4'd0) begin
            fails++; $display("FAIL reset_outputs got en=%b busy=%b rv=%b done=%b err=%b w=%h in=%h rd=%h ri=%h want all zero", sa_en, busy, res_valid, done, err, sa_w, sa_in, res_data, res_idx);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, err} !== 3'b100) begin fails++; $display("FAIL post_reset_idle got ready/busy/err=%b want 100", {cmd_ready, busy, err}); end
    endtask

    task automatic test_errors;
        cmd(2'd3, 0);
        cmd(2'd1, 32'h030201);
        cmd(2'd1, 32'h060504);
        cmd(2'd2, 0);
        checks++;
        if ({busy, err} !== 2'b01) begin fails++; $display("FAIL start_short got busy/err=%b want 01", {busy, err}); end
        cmd(2'd3, 0);
        checks++;
        if (err !== 1'b0 || sa_w !== 72'd0) begin fails++; $display("FAIL clear got err=%b w=%h want 0 0", err, sa_w); end
        cmd(2'd1, 32'h030201);
        cmd(2'd1, 32'h060504);
        cmd(2'd1, 32'h090807);
        checks++;
        if (err !== 1'b0) begin fails++; $display("FAIL three_ldi_after_clear got err=%b want 0", err); end
        cmd(2'd1, 32'hFFFFFF);
        checks++;
        if (err !== 1'b1) begin fails++; $display("FAIL fourth_ldi got err=%b want 1", err); end
    endtask

    task automatic test_weights;
        for (int v = 1; v <= 10; v++) cmd(2'd0, 32'(v));
        for (int i = 0; i < 9; i++) exp_w[i*8+:8] = (i == 0) ? 8'd10 : 8'(i + 1);
        checks++;
        if (sa_w !== exp_w) begin fails++; $display("FAIL weights_wrap got %h want %h", sa_w, exp_w); end
    endtask

    task automatic test_skew_capture;
        res_ready = 1'b0;
        cmd(2'd2, 0);
        for (int t = 0; t < 7; t++) begin
            checks++;
            if (sa_en !== 1'b1 || sa_in !== skew[t]) begin fails++; $display("FAIL skew_t%0d got en=%b in=%h want 1 %h", t, sa_en, sa_in, skew[t]); end
            @(negedge clk);
        end
        checks++;
        if ({sa_en, res_valid, sa_in} !== {2'b01, 24'd0}) begin fails++; $display("FAIL run_end got en=%b rv=%b in=%h want 0 1 0", sa_en, res_valid, sa_in); end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (res_valid !== 1'b1 || res_idx !== 4'(k) || res_data !== exp_res(k)) begin
                fails++; $display("FAIL capture_idx%0d got v=%b idx=%0d data=%h want 1 %0d %h", k, res_valid, res_idx, res_data, k, exp_res(k));
            end
            res_ready = 1'b1;
            @(negedge clk);
        end
        res_ready = 1'b0;
        checks++;
        if ({done, busy, cmd_ready} !== 3'b101) begin fails++; $display("FAIL done_pulse got done/busy/ready=%b want 101", {done, busy, cmd_ready}); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || sa_w !== exp_w) begin fails++; $display("FAIL after_emit got done=%b w=%h want 0 %h", done, sa_w, exp_w); end
    endtask

    task automatic test_backpressure;
        int n = 0, nexp = 0, dones = 0;
        logic stalled = 1'b0;
        logic [15:0] hold = '0;
        logic [3:0] pat = 4'b1001;
        cmd(2'd1, 32'h030201);
        cmd(2'd1, 32'h060504);
        cmd(2'd1, 32'h090807);
        cmd(2'd2, 0);
        while (!res_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (res_valid !== 1'b1) begin fails++; $display("FAIL emit_timeout got res_valid=%b want 1", res_valid); end
        for (int c = 0; c < 80; c++) begin
            if (done) dones++;
            if (nexp == 9 && !busy) break;
            if (res_valid) begin
                checks++;
                if (res_idx !== 4'(nexp) || res_data !== exp_res(nexp) || (stalled && res_data !== hold)) begin
                    fails++; $display("FAIL bp_idx got idx=%0d data=%h want %0d %h", res_idx, res_data, nexp, exp_res(nexp));
                end
            end
            res_ready = pat[c % 4];
            stalled = res_valid && !res_ready;
            hold = res_data;
            if (res_valid && res_ready) nexp++;
            @(negedge clk);
        end
        res_ready = 1'b0;
        @(negedge clk);
        if (done) dones++;
        checks++;
        if (nexp != 9 || dones != 1) begin fails++; $display("FAIL bp_count got delivered=%0d dones=%0d want 9 1", nexp, dones); end
    endtask

    task automatic test_reset_mid_run;
        cmd(2'd1, 32'h030201);
        cmd(2'd1, 32'h060504);
        cmd(2'd1, 32'h090807);
        cmd(2'd2, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (sa_in !== 24'h060800 || sa_en !== 1'b1) begin fails++; $display("FAIL pre_reset_t3 got en=%b in=%h want 1 060800", sa_en, sa_in); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({sa_en, busy, res_valid, done} !== 4'b0 || sa_in !== 24'd0) begin fails++; $display("FAIL async_reset got en=%b busy=%b rv=%b in=%h want 0 0 0 0", sa_en, busy, res_valid, sa_in); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || sa_w !== 72'd0) begin fails++; $display("FAIL post_reset got ready=%b w=%h want 1 0", cmd_ready, sa_w); end
    endtask

    initial begin
        test_reset;
        test_errors;
        test_weights;
        test_skew_capture;
        test_backpressure;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
